adc_avg_bcd: RTL

- Sits between the SPI ADC reader and the 7-segment display controller.
- Captures 12-bit ADC samples qualified by the reader's data-valid, averages a window of 2^AVG_LOG2 samples, and converts the average to four BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Drives the thousands/hundreds/tens/ones digit inputs of the display controller, so the display shows the averaged ADC code (0..4095) rather than a free-running count.

---
 rtl/adc_avg_bcd.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/adc_avg_bcd.sv
// Averages a window of 2^AVG_LOG2 ADC samples and converts the average to
// four BCD digits with a sequential shift-add-3 engine for the 7-seg driver.
module adc_avg_bcd #(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_data_valid,
    output logic [3:0]        o_ones,
    output logic [3:0]        o_tens,
    output logic [3:0]        o_hundreds,
    output logic [3:0]        o_thousands,
    output logic              o_bcd_valid,
    output logic              o_busy,
    output logic              o_overrun
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    // A zero-width counter is illegal, so the no-averaging case keeps one bit.
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int IT_W  = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [IT_W-1:0]  IT_LAST  = IT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    logic              valid_q;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] avg_q, avg_d;
    logic              avg_vld_q, avg_vld_d;
    state_t            state_q, state_d;
    logic [IT_W-1:0]   iter_q, iter_d;
    logic [DATA_W-1:0] bin_q, bin_d;
    logic [15:0]       bcd_q, bcd_d;
    logic [15:0]       digits_q, digits_d;
    logic              bcd_vld_q, bcd_vld_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;

    logic              capture;
    logic [ACC_W-1:0]  sum;
    logic [15:0]       bcd_adj;

    // Rising edge of the qualifier: a held-high valid counts once.
    assign capture = i_data_valid & ~valid_q;
    assign sum     = acc_q + ACC_W'(i_data);

    // Adds 3 to every BCD nibble that is 5 or more, ahead of the shift.
    function automatic logic [15:0] add3(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Accumulate captured samples; emit one registered average per window.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        avg_d     = avg_q;
        avg_vld_d = 1'b0;
        if (capture) begin
            if (cnt_q == CNT_LAST) begin
                acc_d     = '0;
                cnt_d     = '0;
                avg_d     = DATA_W'(sum >> AVG_LOG2);
                avg_vld_d = 1'b1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Converter FSM: load, DATA_W shift-add-3 iterations, then publish digits.
    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        digits_d  = digits_q;
        busy_d    = busy_q;
        bcd_vld_d = 1'b0;
        overrun_d = 1'b0;
        bcd_adj   = add3(bcd_q);
        case (state_q)
            IDLE: begin
                if (avg_vld_q) begin
                    bin_d   = avg_q;
                    bcd_d   = '0;
                    iter_d  = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d  = {bcd_adj[14:0], bin_q[DATA_W-1]};
                bin_d  = {bin_q[DATA_W-2:0], 1'b0};
                iter_d = iter_q + IT_W'(1);
                if (iter_q == IT_LAST) state_d = DONE;
            end
            DONE: begin
                digits_d  = bcd_q;
                bcd_vld_d = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // An average arriving while the engine is occupied is dropped, not queued.
        if (avg_vld_q && state_q != IDLE) overrun_d = 1'b1;
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            valid_q   <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            avg_q     <= '0;
            avg_vld_q <= 1'b0;
            state_q   <= IDLE;
            iter_q    <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            digits_q  <= '0;
            bcd_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= i_data_valid;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            avg_q     <= avg_d;
            avg_vld_q <= avg_vld_d;
            state_q   <= state_d;
            iter_q    <= iter_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            digits_q  <= digits_d;
            bcd_vld_q <= bcd_vld_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_thousands = digits_q[15:12];
    assign o_hundreds  = digits_q[11:8];
    assign o_tens      = digits_q[7:4];
    assign o_ones      = digits_q[3:0];
    assign o_bcd_valid = bcd_vld_q;
    assign o_busy      = busy_q;
    assign o_overrun   = overrun_q;

endmodule
